// File: rtl/fcvt_int2fp_arbiter_if.sv
// Bundle of request, response and converter-side signals for the int-to-float arbiter.
// The arbiter is the slave; the requesters, consumer and converter form the master side.
interface fcvt_int2fp_arbiter_if #(
  parameter int TAG_W = 4
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [31:0]      req_a0;
  logic [31:0]      req_a1;
  logic [1:0]       req_signed;
  logic [TAG_W-1:0] req_tag0;
  logic [TAG_W-1:0] req_tag1;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_data;
  logic             resp_err;

  logic [31:0]      cvt_a;
  logic             cvt_rst;
  logic [31:0]      cvt_z;
  logic             cvt_stb;

  modport slave (
    input  req_valid, req_a0, req_a1, req_signed, req_tag0, req_tag1,
    input  resp_ready, cvt_z, cvt_stb,
    output req_ready, resp_valid, resp_id, resp_tag, resp_data, resp_err,
    output cvt_a, cvt_rst
  );

  modport master (
    output req_valid, req_a0, req_a1, req_signed, req_tag0, req_tag1,
    output resp_ready, cvt_z, cvt_stb,
    input  req_ready, resp_valid, resp_id, resp_tag, resp_data, resp_err,
    input  cvt_a, cvt_rst
  );
endinterface

// File: rtl/fcvt_int2fp_arbiter.sv
// Round-robin sequencer for the shared unsigned int-to-float converter: handles sign
// pre-negation / post-insertion, converter start/release, watchdog and tagged response.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for a request; req_ready one-hot to grant winner
//   S_LAUNCH  | operand presented, converter released from reset
//   S_WAIT    | waiting for cvt_stb; watchdog running
//   S_RELEASE | converter held in reset to clear its sticky strobe
//   S_RESP    | response valid until the consumer takes it
module fcvt_int2fp_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fcvt_int2fp_arbiter_if.slave bus
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RELEASE,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              neg_q;
  logic [WD_W-1:0]   wd_q;
  logic [31:0]       cvt_a_q;
  logic              resp_id_q;
  logic [TAG_W-1:0]  resp_tag_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;

  logic              grant;
  logic [1:0]        req_ready;
  logic              accept;
  logic              cvt_rst;
  logic              resp_valid;
  logic              timeout;

  logic [31:0]       sel_a;
  logic              sel_signed;
  logic [TAG_W-1:0]  sel_tag;
  logic              sel_neg;
  logic [31:0]       sel_mag;

  // Both requesting: the one that did not win last time gets the converter.
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    sel_a      = grant ? bus.req_a1 : bus.req_a0;
    sel_tag    = grant ? bus.req_tag1 : bus.req_tag0;
    sel_signed = bus.req_signed[grant];
    sel_neg    = sel_signed & sel_a[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    sel_mag    = sel_neg ? (~sel_a + 32'd1) : sel_a;
  end

  assign timeout = (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 2'b00;
    accept     = 1'b0;
    cvt_rst    = 1'b1;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid != 2'b00) begin
          req_ready = grant ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cvt_rst = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cvt_rst = 1'b0;
        if (bus.cvt_stb || timeout) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      neg_q        <= 1'b0;
      wd_q         <= '0;
      cvt_a_q      <= 32'd0;
      resp_id_q    <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            last_grant_q <= grant;
            neg_q        <= sel_neg;
            cvt_a_q      <= sel_mag;
            resp_id_q    <= grant;
            resp_tag_q   <= sel_tag;
          end
        end
        S_LAUNCH: begin
          wd_q <= '0;
        end
        S_WAIT: begin
          wd_q <= wd_q + 1'b1;
          // A strobe arriving together with the timeout still counts as a result.
          if (bus.cvt_stb) begin
            resp_data_q <= {bus.cvt_z[31] | neg_q, bus.cvt_z[30:0]};
            resp_err_q  <= 1'b0;
          end else if (timeout) begin
            resp_data_q <= QNAN;
            resp_err_q  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.cvt_a      = cvt_a_q;
  assign bus.cvt_rst    = cvt_rst;

endmodule

// File: tb/tb_fcvt_int2fp_arbiter.sv
// Scoreboard bench for fcvt_int2fp_arbiter with a behavioural converter model
// that can be told to never strobe.
module tb_fcvt_int2fp_arbiter;
  localparam int TO  = 64;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcvt_int2fp_arbiter_if #(.TAG_W(4)) bus ();

  fcvt_int2fp_arbiter #(.TIMEOUT_CYCLES(TO), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic        sgn;
    logic [3:0]  tag;
    logic [31:0] exp;
    logic        err;
  } op_t;

  typedef struct {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  op_t  pend0[$];
  op_t  pend1[$];
  rsp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic        busy = 1'b0;
  logic        last_g = 1'b1;
  logic [31:0] inflight_mag = 32'd0;
  int          wait_cnt = 0;
  logic        hold_next = 1'b0;
  int          hold_cnt = 0;
  rsp_t        snap;
  logic        first_chk = 1'b0;
  logic        dead = 1'b0;
  int          cvt_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] u2f(input logic [31:0] a);
    int          p;
    logic [31:0] m, rem, half;
    logic [7:0]  e;
    if (a == 32'd0) return 32'd0;
    p = 31;
    while (!a[p]) p--;
    e = 8'(127 + p);
    if (p <= 23) begin
      m = a << (23 - p);
    end else begin
      m    = a >> (p - 23);
      rem  = a & ((32'd1 << (p - 23)) - 32'd1);
      half = 32'd1 << (p - 24);
      if (rem > half || (rem == half && m[0])) m = m + 32'd1;
      if (m[24]) begin
        m = m >> 1;
        e = e + 8'd1;
      end
    end
    return {1'b0, e, m[22:0]};
  endfunction

  // Converter model: strobe LAT cycles after release, sticky until cvt_rst.
  always @(negedge clk) begin
    if (bus.cvt_rst) begin
      bus.cvt_stb = 1'b0;
      cvt_cnt     = 0;
    end else if (!bus.cvt_stb && !dead) begin
      cvt_cnt++;
      if (cvt_cnt == LAT) begin
        bus.cvt_stb = 1'b1;
        bus.cvt_z   = u2f(bus.cvt_a);
      end
    end
  end

  task automatic push(input int who, input logic [31:0] a, input logic sgn,
                      input logic [3:0] tag, input logic [31:0] exp, input logic err);
    op_t o;
    o = '{a: a, sgn: sgn, tag: tag, exp: exp, err: err};
    if (who == 0) pend0.push_back(o);
    else pend1.push_back(o);
  endtask

  task automatic drive();
    logic [1:0] sg;
    sg = 2'b00;
    bus.req_valid = {pend1.size() != 0, pend0.size() != 0};
    if (pend0.size() != 0) begin
      bus.req_a0 = pend0[0].a; bus.req_tag0 = pend0[0].tag; sg[0] = pend0[0].sgn;
    end else begin
      bus.req_a0 = 32'd0; bus.req_tag0 = 4'd0;
    end
    if (pend1.size() != 0) begin
      bus.req_a1 = pend1[0].a; bus.req_tag1 = pend1[0].tag; sg[1] = pend1[0].sgn;
    end else begin
      bus.req_a1 = 32'd0; bus.req_tag1 = 4'd0;
    end
    bus.req_signed = sg;
    bus.resp_ready = !(hold_next || hold_cnt > 0);
  endtask

  task automatic step();
    logic [1:0] v, exp_rdy, acc;
    logic       eg, id;
    op_t        o;
    rsp_t       e;
    @(posedge clk);
    #1 drive();
    #1;
    v       = bus.req_valid;
    eg      = (v == 2'b11) ? !last_g : v[1];
    exp_rdy = (!busy && v != 2'b00) ? (eg ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    acc = bus.req_valid & bus.req_ready;
    if (acc != 2'b00) begin
      id = acc[1];
      if (first_chk) begin
        chk("first_grant", 32'(id), 32'd0);
        first_chk = 1'b0;
      end
      if (id) o = pend1.pop_front();
      else    o = pend0.pop_front();
      sb.push_back('{id: id, tag: o.tag, data: o.exp, err: o.err});
      busy         = 1'b1;
      last_g       = id;
      inflight_mag = (o.sgn && o.a[31]) ? (32'd0 - o.a) : o.a;
      wait_cnt     = 0;
    end
    if (!bus.cvt_rst) begin
      chk("cvt_a", bus.cvt_a, inflight_mag);
      wait_cnt++;
    end
    if (bus.resp_valid) begin
      chk("cvt_rst_in_resp", 32'(bus.cvt_rst), 32'd1);
      if (hold_next) begin
        hold_next = 1'b0;
        hold_cnt  = 10;
        snap = '{id: bus.resp_id, tag: bus.resp_tag, data: bus.resp_data, err: bus.resp_err};
      end else if (hold_cnt > 0) begin
        chk("hold_data", bus.resp_data, snap.data);
        chk("hold_tag",  32'(bus.resp_tag), 32'(snap.tag));
        chk("hold_id",   32'(bus.resp_id), 32'(snap.id));
        hold_cnt--;
      end
      if (bus.resp_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_id",   32'(bus.resp_id), 32'(e.id));
          chk("resp_tag",  32'(bus.resp_tag), 32'(e.tag));
          chk("resp_data", bus.resp_data, e.data);
          chk("resp_err",  32'(bus.resp_err), 32'(e.err));
          if (e.err) chk("wait_len", 32'(wait_cnt), 32'(TO + 1));
        end
        busy = 1'b0;
      end
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0 || busy) && n < limit) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(n < limit), 32'd1);
  endtask

  initial begin
    int n;
    bus.req_valid = 2'b00; bus.req_a0 = 32'd0; bus.req_a1 = 32'd0;
    bus.req_signed = 2'b00; bus.req_tag0 = 4'd0; bus.req_tag1 = 4'd0;
    bus.resp_ready = 1'b0; bus.cvt_z = 32'd0; bus.cvt_stb = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready",  32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_cvt_rst",    32'(bus.cvt_rst), 32'd1);
    chk("rst_cvt_a",      bus.cvt_a, 32'd0);
    chk("rst_resp_data",  bus.resp_data, 32'd0);
    chk("rst_resp_err",   32'(bus.resp_err), 32'd0);
    chk("rst_resp_id",    32'(bus.resp_id), 32'd0);
    chk("rst_resp_tag",   32'(bus.resp_tag), 32'd0);
    rst = 1'b0;

    // Both requesters busy from the start: grants alternate, first response held back.
    first_chk = 1'b1;
    hold_next = 1'b1;
    push(0, 32'h0000_0001, 1'b0, 4'd3,  32'h3F80_0000, 1'b0);
    push(0, 32'h0000_0000, 1'b0, 4'd10, 32'h0000_0000, 1'b0);
    push(0, 32'hFFFF_FFFF, 1'b0, 4'd11, 32'h4F80_0000, 1'b0);
    push(0, 32'h0100_0001, 1'b0, 4'd14, 32'h4B80_0000, 1'b0);
    push(1, 32'hFFFF_FFFF, 1'b1, 4'd5,  32'hBF80_0000, 1'b0);
    push(1, 32'h8000_0000, 1'b1, 4'd6,  32'hCF00_0000, 1'b0);
    push(1, 32'h0000_0000, 1'b1, 4'd7,  32'h0000_0000, 1'b0);
    push(1, 32'hFFFF_FFFD, 1'b1, 4'd15, 32'hC040_0000, 1'b0);
    push(1, 32'h7FFF_FFFF, 1'b1, 4'd9,  32'h4F00_0000, 1'b0);
    drain(2000);

    // Converter never strobes: watchdog error, then normal recovery.
    dead = 1'b1;
    push(0, 32'h0000_0005, 1'b0, 4'd1, 32'h7FC0_0000, 1'b1);
    drain(500);
    dead = 1'b0;
    push(1, 32'h0000_0002, 1'b0, 4'd2, 32'h4000_0000, 1'b0);
    drain(500);

    // Reset in the middle of WAIT.
    push(1, 32'h0000_0007, 1'b0, 4'd4, 32'h40E0_0000, 1'b0);
    n = 0;
    while (!(busy && wait_cnt >= 3) && n < 40) begin
      step();
      n++;
    end
    chk("reach_wait", 32'(busy && wait_cnt >= 3), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_cvt_rst",    32'(bus.cvt_rst), 32'd1);
    chk("midrst_cvt_a",      bus.cvt_a, 32'd0);
    sb.delete();
    busy = 1'b0; last_g = 1'b1; wait_cnt = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    first_chk = 1'b1;
    push(0, 32'h0000_0009, 1'b0, 4'd12, 32'h4110_0000, 1'b0);
    push(1, 32'h0000_0009, 1'b1, 4'd13, 32'h4110_0000, 1'b0);
    drain(500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
